// File: rtl/block_packer_pkg.sv
// Shared definitions for the byte-to-block packer: FSM encoding, default geometry and padding.
// Defining BLOCK_PACKER_PKCS7_EN switches the pad byte from 0x00 to PKCS#7.
package block_packer_pkg;

  localparam int unsigned DefWidth      = 8;
  localparam int unsigned DefBlockBytes = 16;

  typedef logic [0:0] state_t;

  localparam state_t StFill = 1'b0;
  localparam state_t StHold = 1'b1;

`ifdef BLOCK_PACKER_PKCS7_EN
  localparam bit Pkcs7En = 1'b1;
`else
  localparam bit Pkcs7En = 1'b0;
`endif

  // PKCS#7 pads with the number of missing bytes; the plain variant pads with zero.
  function automatic int unsigned pad_value(input int unsigned block_bytes,
                                            input int unsigned count);
    return Pkcs7En ? (block_bytes - count) : 0;
  endfunction

endpackage

// File: rtl/block_packer_if.sv
// Bundle of FIFO read port, flush request and block output handshake around block_packer.
// The master modport is the packer side; the slave modport is the surrounding datapath.
interface block_packer_if #(
  parameter int unsigned WIDTH       = block_packer_pkg::DefWidth,
  parameter int unsigned BLOCK_BYTES = block_packer_pkg::DefBlockBytes,
  parameter int unsigned CW          = $clog2(BLOCK_BYTES + 1)
) ();

  logic [WIDTH-1:0]             i_rd_data;
  logic                         i_empty;
  logic                         o_rd_en;
  logic                         i_flush;
  logic [BLOCK_BYTES*WIDTH-1:0] o_block;
  logic                         o_valid;
  logic                         i_ready;
  logic [CW-1:0]                o_count;

  modport master (
    input  i_rd_data,
    input  i_empty,
    input  i_flush,
    input  i_ready,
    output o_rd_en,
    output o_block,
    output o_valid,
    output o_count
  );

  modport slave (
    output i_rd_data,
    output i_empty,
    output i_flush,
    output i_ready,
    input  o_rd_en,
    input  o_block,
    input  o_valid,
    input  o_count
  );

endinterface

// File: rtl/block_pad_gen.sv
// Combinational pad generator: marks lanes count..BLOCK_BYTES-1 and fills them with the pad byte.
// Lane 0 is the most significant byte of the block.
module block_pad_gen
  import block_packer_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned BLOCK_BYTES = DefBlockBytes,
  parameter int unsigned CW          = $clog2(BLOCK_BYTES + 1)
) (
  input  logic [CW-1:0]                count_i,
  output logic [BLOCK_BYTES*WIDTH-1:0] pad_mask_o,
  output logic [BLOCK_BYTES*WIDTH-1:0] pad_data_o
);

  logic [WIDTH-1:0] pad_byte;

  assign pad_byte = WIDTH'(pad_value(BLOCK_BYTES, 32'(count_i)));

  always_comb begin
    pad_mask_o = '0;
    pad_data_o = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (i >= 32'(count_i)) begin
        pad_mask_o[(BLOCK_BYTES-1-i)*WIDTH +: WIDTH] = '1;
        pad_data_o[(BLOCK_BYTES-1-i)*WIDTH +: WIDTH] = pad_byte;
      end
    end
  end

endmodule

// File: rtl/block_packer.sv
// Pops bytes from the upstream FIFO, packs BLOCK_BYTES of them MSB-lane first and hands the block
// downstream over valid/ready. A flush closes a partial block; BLOCK_PACKER_PKCS7_EN picks padding.
module block_packer
  import block_packer_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned BLOCK_BYTES = DefBlockBytes,
  parameter int unsigned CW          = $clog2(BLOCK_BYTES + 1)
) (
  input logic            i_clk,
  input logic            i_rst_n,
  block_packer_if.master bus
);

  localparam int unsigned   BlockW    = BLOCK_BYTES * WIDTH;
  localparam logic [CW-1:0] FullCount = CW'(BLOCK_BYTES);

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              inflight_q;
  logic              flush_pend_q, flush_pend_d;
  logic [BlockW-1:0] block_q, block_d;
  logic [BlockW-1:0] pad_mask, pad_data;
  logic [CW:0]       reserved;
  logic              rd_en;
  int unsigned       lane;

  // Bytes already captured plus the one still in flight from the FIFO.
  assign reserved = {1'b0, count_q} + (CW+1)'(inflight_q);

  assign rd_en = i_rst_n && (state_q == StFill) && !bus.i_empty && !flush_pend_q &&
                 (reserved < {1'b0, FullCount});

  block_pad_gen #(
    .WIDTH       (WIDTH),
    .BLOCK_BYTES (BLOCK_BYTES),
    .CW          (CW)
  ) u_pad_gen (
    .count_i    (count_q),
    .pad_mask_o (pad_mask),
    .pad_data_o (pad_data)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    block_d      = block_q;
    flush_pend_d = flush_pend_q | bus.i_flush;
    lane         = BLOCK_BYTES - 1 - 32'(count_q);
    unique case (state_q)
      StFill: begin
        if (inflight_q) begin
          block_d[lane*WIDTH +: WIDTH] = bus.i_rd_data;
          count_d = count_q + CW'(1);
          if (count_d == FullCount) begin
            state_d = StHold;
          end
        end else if (flush_pend_q) begin
          // A pulse landing on the consuming edge merges into this flush.
          flush_pend_d = 1'b0;
          if ((count_q != '0) || Pkcs7En) begin
            block_d = (block_q & ~pad_mask) | pad_data;
            count_d = FullCount;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bus.i_ready) begin
          count_d = '0;
          block_d = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StFill;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      block_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      inflight_q   <= rd_en;
      flush_pend_q <= flush_pend_d;
      block_q      <= block_d;
    end
  end

  assign bus.o_rd_en = rd_en;
  assign bus.o_valid = (state_q == StHold);
  assign bus.o_block = block_q;
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_block_packer.sv
// Scoreboard bench for block_packer: a byte-stream model predicts blocks, a monitor checks them.
module tb_block_packer;

  localparam int unsigned W   = 8;
  localparam int unsigned BB  = 16;
  localparam int unsigned CWD = $clog2(BB + 1);
  localparam int unsigned BW  = W * BB;

`ifdef BLOCK_PACKER_PKCS7_EN
  localparam bit Pkcs = 1'b1;
`else
  localparam bit Pkcs = 1'b0;
`endif

  logic tb_clk   = 1'b0;
  logic tb_rst_n = 1'b1;
  always #5 tb_clk = ~tb_clk;

  block_packer_if #(.WIDTH(W), .BLOCK_BYTES(BB), .CW(CWD)) bus ();

  block_packer #(
    .WIDTH       (W),
    .BLOCK_BYTES (BB),
    .CW          (CWD)
  ) dut (
    .i_clk   (tb_clk),
    .i_rst_n (tb_rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0]  fifo[$];
  logic [W-1:0]  stream[$];
  logic [BW-1:0] exp_q[$];
  logic          pop_now   = 1'b0;
  logic          stall     = 1'b0;
  logic          rand_mode = 1'b0;
  logic          prev_hold = 1'b0;
  logic [BW-1:0] prev_block;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] pack(input logic [W-1:0] b[$]);
    logic [BW-1:0] r;
    r = '0;
    foreach (b[i]) r = {r[BW-W-1:0], b[i]};
    return r;
  endfunction

  task automatic upd();
    bus.i_empty = (fifo.size() == 0) || stall;
  endtask

  task automatic push_byte(input logic [W-1:0] b);
    fifo.push_back(b);
    stream.push_back(b);
    if (stream.size() == BB) begin
      exp_q.push_back(pack(stream));
      stream.delete();
    end
    upd();
  endtask

  // Stream-level flush: whatever is buffered becomes one padded block.
  task automatic model_flush();
    int n;
    logic [W-1:0] pad;
    n = stream.size();
    if (n > 0 || Pkcs) begin
      pad = Pkcs ? W'(BB - n) : '0;
      while (stream.size() < BB) stream.push_back(pad);
      exp_q.push_back(pack(stream));
      stream.delete();
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
    if (pop_now && fifo.size() > 0) bus.i_rd_data = fifo.pop_front();
    else bus.i_rd_data = W'($urandom);
    if (rand_mode) begin
      bus.i_ready = ($urandom_range(3) != 0);
      stall = ($urandom_range(4) == 0);
    end
    upd();
  endtask

  task automatic wait_fifo_empty();
    int n;
    n = 0;
    while (fifo.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("fifo_drain", fifo.size(), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("drain_done", exp_q.size() + fifo.size(), 0);
  endtask

  task automatic flush_pulse();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    model_flush();
  endtask

  // Monitor: samples mid-cycle, compares each accepted block against the scoreboard queue.
  always @(negedge tb_clk) begin
    if (tb_rst_n) begin
      chk("rd_en_legal", bus.o_rd_en && (bus.i_empty || bus.o_valid), 0);
      if (prev_hold && bus.o_valid) chk("hold_stable", bus.o_block, prev_block);
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_block: got %h expected none", bus.o_block);
        end else begin
          chk("block", bus.o_block, exp_q.pop_front());
        end
      end
      prev_hold  = bus.o_valid && !bus.i_ready;
      prev_block = bus.o_block;
    end else begin
      prev_hold = 1'b0;
    end
    pop_now = bus.o_rd_en;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_flush   = 1'b0;
    bus.i_ready   = 1'b1;
    bus.i_rd_data = '0;
    upd();
    #1 tb_rst_n = 1'b0;
    #1;
    bus.i_empty = 1'b0;
    #1;
    chk("rst_rd_en", bus.o_rd_en, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_block", bus.o_block, 0);
    chk("rst_count", bus.o_count, 0);
    upd();
    repeat (2) tick();
    tb_rst_n = 1'b1;
    tick();

    // Sequential bytes, latency and single-cycle valid.
    for (int i = 0; i < 16; i++) push_byte(W'(i));
    n = 0;
    while (!bus.o_valid && n < 200) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 17);
    chk("t1_block", bus.o_block, 128'h000102030405060708090a0b0c0d0e0f);
    tick();
    chk("t1_valid_drop", bus.o_valid, 0);
    chk("t1_count_zero", bus.o_count, 0);

    // Backpressure across two blocks.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 32; i++) push_byte(W'(i));
    n = 0;
    while (!bus.o_valid && n < 200) begin
      tick();
      n++;
    end
    repeat (5) begin
      chk("t2_rd_en_hold", bus.o_rd_en, 0);
      chk("t2_block_hold", bus.o_block, 128'h000102030405060708090a0b0c0d0e0f);
      chk("t2_count_full", bus.o_count, 16);
      tick();
    end
    chk("t2_fifo_left", fifo.size(), 16);
    bus.i_ready = 1'b1;
    wait_done();

    // Partial block flush.
    for (int i = 0; i < 5; i++) push_byte(W'(8'hA0 + i));
    wait_fifo_empty();
    chk("t3_count5", bus.o_count, 5);
    flush_pulse();
    chk("t3_valid_early", bus.o_valid, 0);
    tick();
    chk("t3_flush_latency", bus.o_valid, 1);
    chk("t3_block", bus.o_block, Pkcs ? 128'ha0a1a2a3a40b0b0b0b0b0b0b0b0b0b0b
                                       : 128'ha0a1a2a3a40000000000000000000000);
    wait_done();

    // Flush with nothing captured.
    flush_pulse();
    tick();
    chk("t4_valid", bus.o_valid, Pkcs);
    wait_done();
    chk("t4_count", bus.o_count, 0);

    // FIFO runs dry mid-block, refills later.
    for (int i = 0; i < 7; i++) push_byte(W'(8'h40 + i));
    wait_fifo_empty();
    repeat (20) begin
      chk("t5_count_hold", bus.o_count, 7);
      tick();
    end
    for (int i = 7; i < 16; i++) push_byte(W'(8'h40 + i));
    wait_done();

    // Asynchronous reset in the middle of a block.
    for (int i = 0; i < 16; i++) push_byte(W'(8'h80 + i));
    n = 0;
    while (bus.o_count != 9 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_count9", bus.o_count, 9);
    tb_rst_n = 1'b0;
    #1;
    chk("t6_rst_block", bus.o_block, 0);
    chk("t6_rst_count", bus.o_count, 0);
    chk("t6_rst_valid", bus.o_valid, 0);
    chk("t6_rst_rd_en", bus.o_rd_en, 0);
    fifo.delete();
    stream.delete();
    exp_q.delete();
    upd();
    repeat (2) tick();
    tb_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) push_byte(W'(8'h30 + i));
    wait_done();

    // Randomized traffic with backpressure, stalls and flushes.
    rand_mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(40, 1);
      for (int i = 0; i < n; i++) push_byte(W'($urandom));
      repeat ($urandom_range(30)) tick();
      if ($urandom_range(1) == 1) begin
        wait_fifo_empty();
        flush_pulse();
      end
    end
    rand_mode   = 1'b0;
    stall       = 1'b0;
    bus.i_ready = 1'b1;
    upd();
    wait_fifo_empty();
    flush_pulse();
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_packer.md
# block_packer

Byte-to-block assembler sitting directly downstream of the byte FIFO in the encryption datapath. Pops 8-bit bytes from the FIFO read port, packs BLOCK_BYTES of them into one wide block (first byte popped in the MSB lane), and presents the block to the cipher core over a valid/ready handshake. Supports a flush request that closes out a partial block with padding.

## Interface
- WIDTH, 8, byte width; must equal the FIFO data width
- BLOCK_BYTES, 16, bytes per output block; 2..255
- CW, $clog2(BLOCK_BYTES+1), width of o_count
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_rd_data  in  WIDTH  FIFO read data; valid the cycle after o_rd_en was sampled high
- i_empty  in  1  FIFO empty flag
- o_rd_en  out  1  FIFO pop request (combinational)
- i_flush  in  1  single-cycle pulse: close current block
- o_block  out  BLOCK_BYTES*WIDTH  assembled block; byte 0 at [BLOCK_BYTES*WIDTH-1 -: WIDTH]
- o_valid  out  1  o_block valid
- i_ready  in  1  downstream accepts when o_valid & i_ready at a rising edge
- o_count  out  CW  bytes currently captured in the block under assembly

## Operation
- States: FILL, HOLD. Reset -> FILL.
- FILL: o_rd_en = !i_empty & !flush_pend & (count + inflight < BLOCK_BYTES). inflight is a 1-bit register = o_rd_en of the previous cycle.
- Capture: when inflight = 1, i_rd_data written to lane `count`; count increments.
- count reaches BLOCK_BYTES -> HOLD, o_valid = 1.
- HOLD: o_rd_en = 0; o_block and o_valid stable until i_ready. On handshake: count = 0, o_block cleared, -> FILL.
- Flush: i_flush sets flush_pend (in any state; a pulse in HOLD is retained). In FILL with flush_pend = 1 and inflight = 0:
  - count > 0: lanes count..BLOCK_BYTES-1 filled with the pad byte, -> HOLD, flush_pend cleared.
  - count = 0: behaviour per Configuration.
- flush_pend blocks new pops; the in-flight byte is still captured before padding.
- Flush pulses arriving while flush_pend = 1 merge into one.
- i_empty high mid-block: packer waits in FILL indefinitely; no timeout.

## Timing
- Reset values: o_valid 0, o_block 0, o_count 0, o_rd_en 0, state FILL, inflight 0, flush_pend 0.
- Reset asserted mid-block or in HOLD: partial data and the pending block are discarded immediately.
- Throughput: one byte per cycle while the FIFO is non-empty. First pop sampled at edge k -> o_valid high after edge k+BLOCK_BYTES (17-cycle latency for 16 bytes).
- No pops occur during HOLD; minimum one-cycle FILL gap between blocks after a handshake.
- Flush: with inflight = 0, o_valid rises one edge after the edge that samples i_flush.
- o_rd_en never high while i_empty = 1, in HOLD, or in reset.

## Configuration
- BLOCK_PACKER_PKCS7_EN defined:
  - pad byte = BLOCK_BYTES - count (PKCS#7).
  - Flush with count = 0 emits a full block of bytes equal to BLOCK_BYTES (0x10 for 16).
- Undefined:
  - pad byte = 0x00.
  - Flush with count = 0 clears flush_pend and emits nothing.

## Structure
- Package block_packer_pkg holds:
  - state encoding (FILL, HOLD)
  - default WIDTH and BLOCK_BYTES
  - pad-byte function
- One sub-module, block_pad_gen: combinational; takes count and produces the padded lane mask/value vector merged into o_block at flush.

## Test plan
- Write bytes 0x00..0x0F to FIFO, i_ready = 1 -> one block 0x000102...0E0F; o_valid high exactly one cycle; o_count returns to 0.
- 32 bytes with i_ready held low for 5 cycles after the first o_valid -> o_block stable, o_rd_en = 0 during HOLD; second block 0x10..0x1F follows with no byte lost or reordered.
- Bytes 0xA0..0xA4, then i_flush -> PKCS7_EN: lanes 5..15 = 0x0B; without: lanes 5..15 = 0x00.
- i_flush with count = 0 -> PKCS7_EN: block of sixteen 0x10; without: o_valid stays 0.
- FIFO empties after 7 bytes, refills 20 cycles later -> o_count holds at 7; block completes correctly on refill.
- i_rst_n pulsed low with count = 9 -> outputs zero asynchronously; next 16 bytes form a clean block.
